dmem_arbiter: RTL and testbench

//  Two-requester arbiter and sequencer for the single-port data memory.

---
 rtl/dmem_arbiter_if.sv | 60 ++++++
 rtl/dmem_arbiter.sv | 162 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 396 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// ---------------------------------------------------------------------------
// dmem_arbiter_if
//   Bundles the two requester ports and the single-port data memory bus of
//   the data-memory arbiter.
//
//   Requester port k (k = 0 pipeline MEM stage, k = 1 debug/DMA loader):
//     mk_req, mk_we, mk_addr, mk_wdata  : command, held until mk_gnt
//     mk_gnt                            : command accepted this cycle
//     mk_rvalid, mk_rdata               : read response, 2 cycles after grant
//   Memory side:
//     mem_we, mem_a, mem_wd             : access issued to the memory
//     mem_rd                            : read data, combinational from mem_a
//
//   Modports:
//     slave  : the arbiter
//     master : the environment (requesters and the memory array)
// ---------------------------------------------------------------------------
interface dmem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          m0_req;
    logic          m0_we;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic          m0_gnt;
    logic          m0_rvalid;
    logic [DW-1:0] m0_rdata;

    logic          m1_req;
    logic          m1_we;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic          m1_gnt;
    logic          m1_rvalid;
    logic [DW-1:0] m1_rdata;

    logic          mem_we;
    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_wd;
    logic [DW-1:0] mem_rd;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_gnt, m0_rvalid, m0_rdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output mem_we, mem_a, mem_wd,
        input  mem_rd
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_gnt, m0_rvalid, m0_rdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  mem_we, mem_a, mem_wd,
        output mem_rd
    );
endinterface

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//   Two-requester arbiter and sequencer for the single-port data memory.
//   One command is granted per cycle and registered into a one-entry issue
//   stage that drives the memory in the following cycle. Read data is
//   captured into a response stage, giving a 2-cycle read latency with a
//   throughput of one access per cycle. Accesses reach memory in grant order.
//
//   Ports:
//     clk  : single clock, all state on posedge
//     rst  : asynchronous, active-low reset
//     bus  : dmem_arbiter_if.slave (requester ports 0/1 and memory bus)
//
//   Configuration:
//     DMEM_ARB_FIXED_PRIO_EN  defined   -> port 0 always wins contention
//                             undefined -> round-robin on contention,
//                                          port 0 preferred after reset
// ---------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_e;

    typedef struct packed {
        logic          valid;
        port_e         owner;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } issue_t;

    logic   gnt0;
    logic   gnt1;
    issue_t iss_d;
    issue_t iss_q;
    logic   rsp_valid_q;
    port_e  rsp_owner_q;
    logic [DW-1:0] rdata0_q;
    logic [DW-1:0] rdata1_q;

    // -----------------------------------------------------------------------
    // Arbitration. Grants are forced low while rst is asserted so that no
    // requester believes its command was taken while the pipeline is held.
    // -----------------------------------------------------------------------
`ifdef DMEM_ARB_FIXED_PRIO_EN
    always_comb begin
        gnt0 = bus.m0_req & rst;
        gnt1 = bus.m1_req & ~bus.m0_req & rst;
    end
`else
    port_e rr_q;
    logic  contested;

    // NOTE: every output of an always_comb gets a default before any branch;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        contested = bus.m0_req & bus.m1_req;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        if (rst) begin
            if (contested) begin
                gnt0 = (rr_q == PORT0);
                gnt1 = (rr_q == PORT1);
            end else begin
                gnt0 = bus.m0_req;
                gnt1 = bus.m1_req;
            end
        end
    end

    // The pointer moves only when both ports competed, so an uncontested
    // grant never costs the other port its turn.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_q <= PORT0;
        end else if (contested) begin
            rr_q <= (rr_q == PORT0) ? PORT1 : PORT0;
        end
    end
`endif

    assign bus.m0_gnt = gnt0;
    assign bus.m1_gnt = gnt1;

    // -----------------------------------------------------------------------
    // Issue stage: the command sampled in the grant cycle. Fields stay zero
    // when nothing is granted, so an idle cycle presents a quiet memory bus.
    // -----------------------------------------------------------------------
    always_comb begin
        iss_d = '0;
        if (gnt0) begin
            iss_d.valid = 1'b1;
            iss_d.owner = PORT0;
            iss_d.we    = bus.m0_we;
            iss_d.addr  = bus.m0_addr;
            iss_d.wdata = bus.m0_wdata;
        end else if (gnt1) begin
            iss_d.valid = 1'b1;
            iss_d.owner = PORT1;
            iss_d.we    = bus.m1_we;
            iss_d.addr  = bus.m1_addr;
            iss_d.wdata = bus.m1_wdata;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    // NOTE: the address/data fields are reset along with valid because they
    // drive the memory bus directly and must read zero during reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            iss_q <= '0;
        end else begin
            iss_q <= iss_d;
        end
    end

    assign bus.mem_we = iss_q.valid & iss_q.we;
    assign bus.mem_a  = iss_q.valid ? iss_q.addr  : '0;
    assign bus.mem_wd = iss_q.valid ? iss_q.wdata : '0;

    // -----------------------------------------------------------------------
    // Response stage. Each port keeps its own data register so rdata holds
    // the last value returned to that port between pulses.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_valid_q <= 1'b0;
            rsp_owner_q <= PORT0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            rsp_valid_q <= iss_q.valid & ~iss_q.we;
            rsp_owner_q <= iss_q.owner;
            if (iss_q.valid && !iss_q.we) begin
                if (iss_q.owner == PORT0) begin
                    rdata0_q <= bus.mem_rd;
                end else begin
                    rdata1_q <= bus.mem_rd;
                end
            end
        end
    end

    assign bus.m0_rvalid = rsp_valid_q & (rsp_owner_q == PORT0);
    assign bus.m1_rvalid = rsp_valid_q & (rsp_owner_q == PORT1);
    assign bus.m0_rdata  = rdata0_q;
    assign bus.m1_rdata  = rdata1_q;

    // At most one grant per cycle.
    a_one_grant: assert property (@(posedge clk) disable iff (!rst) !(gnt0 && gnt1));

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
//   Self-checking bench for dmem_arbiter: a directed vector table, hand
//   sequences for reset, contention, cross-port RAW, back-to-back reads and
//   write silence, then randomized traffic against a transaction-level
//   reference (grant-order memory image plus due-cycle response queues).
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic clk;
    logic rst;

    dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    dmem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- memory array (environment) ----------------
    function automatic logic [31:0] init_word(input int i);
        if (i == 16) return 32'hDEAD_BEEF;
        return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
    endfunction

    logic [31:0] mem [0:255];
    logic        init_done;

    assign bus.mem_rd = mem[bus.mem_a[7:0]];

    always @(posedge clk) begin
        if (init_done !== 1'b1) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
            init_done <= 1'b1;
        end else if (bus.mem_we) begin
            mem[bus.mem_a[7:0]] <= bus.mem_wd;
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_err    = 0;

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_err + 1, n_checks + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    logic        r_req   [2];
    logic        r_we    [2];
    logic [31:0] r_addr  [2];
    logic [31:0] r_wdata [2];

    task automatic apply();
        bus.m0_req   = r_req[0];
        bus.m0_we    = r_we[0];
        bus.m0_addr  = r_addr[0];
        bus.m0_wdata = r_wdata[0];
        bus.m1_req   = r_req[1];
        bus.m1_we    = r_we[1];
        bus.m1_addr  = r_addr[1];
        bus.m1_wdata = r_wdata[1];
    endtask

    task automatic set_port(input int p, input logic req, input logic we,
                            input logic [31:0] addr, input logic [31:0] wdata);
        r_req[p]   = req;
        r_we[p]    = we;
        r_addr[p]  = addr;
        r_wdata[p] = wdata;
        apply();
    endtask

    task automatic idle_all();
        set_port(0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_port(1, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_all();
        rst = 1'b0;
        repeat (3) next_cycle();
        rst = 1'b1;
        next_cycle();
    endtask

    // ---------------- reference model state ----------------
    typedef struct {
        int          due;
        int          port;
        logic [31:0] data;
    } rsp_t;

    typedef struct {
        int          due;
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic        port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    logic [31:0] ref_mem [0:255];
    rsp_t        rsp_q [$];
    wr_t         wr_q  [$];
    logic [31:0] last_rd [2];
    int          pref;
    int          cyc;

    vec_t vecs [6];

    initial begin
        vec_t v;
        int   we_cnt;
        int   rv_cnt;

        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        rst = 1'b0;
        idle_all();
        do_reset();

        // ---------------- directed vector table ----------------
        vecs[0] = '{1'b0, 1'b0, 32'h10, 32'h0,         32'hDEAD_BEEF};
        vecs[1] = '{1'b1, 1'b1, 32'h24, 32'hCAFE_F00D, 32'h0};
        vecs[2] = '{1'b0, 1'b0, 32'h24, 32'h0,         32'hCAFE_F00D};
        vecs[3] = '{1'b1, 1'b0, 32'h10, 32'h0,         32'hDEAD_BEEF};
        vecs[4] = '{1'b0, 1'b1, 32'h05, 32'h0BAD_C0DE, 32'h0};
        vecs[5] = '{1'b1, 1'b0, 32'h05, 32'h0,         32'h0BAD_C0DE};

        for (int i = 0; i < 6; i++) begin
            v = vecs[i];
            set_port(int'(v.port), 1'b1, v.we, v.addr, v.wdata);
            @(negedge clk);
            check1($sformatf("vec%0d own gnt", i), v.port ? bus.m1_gnt : bus.m0_gnt, 1'b1);
            check1($sformatf("vec%0d other gnt", i), v.port ? bus.m0_gnt : bus.m1_gnt, 1'b0);
            next_cycle();
            set_port(int'(v.port), 1'b0, 1'b0, 32'h0, 32'h0);
            if (v.we) ref_mem[v.addr[7:0]] = v.wdata;
            @(negedge clk);
            check32($sformatf("vec%0d mem_a", i), bus.mem_a, v.addr);
            check1($sformatf("vec%0d mem_we", i), bus.mem_we, v.we);
            if (v.we) check32($sformatf("vec%0d mem_wd", i), bus.mem_wd, v.wdata);
            next_cycle();
            @(negedge clk);
            check1($sformatf("vec%0d own rvalid", i), v.port ? bus.m1_rvalid : bus.m0_rvalid, ~v.we);
            check1($sformatf("vec%0d other rvalid", i), v.port ? bus.m0_rvalid : bus.m1_rvalid, 1'b0);
            if (!v.we)
                check32($sformatf("vec%0d rdata", i), v.port ? bus.m1_rdata : bus.m0_rdata, v.exp_rdata);
            next_cycle();
        end

        // ---------------- reset in the middle of a port-0 read ----------------
        set_port(0, 1'b1, 1'b0, 32'h10, 32'h0);
        @(negedge clk);
        check1("rst pre gnt", bus.m0_gnt, 1'b1);
        next_cycle();
        set_port(0, 1'b1, 1'b0, 32'h24, 32'h0);
        #1;
        rst = 1'b0;
        #1;
        check1("rst gnt0", bus.m0_gnt, 1'b0);
        check1("rst rvalid0", bus.m0_rvalid, 1'b0);
        check1("rst rvalid1", bus.m1_rvalid, 1'b0);
        check32("rst rdata0", bus.m0_rdata, 32'h0);
        check32("rst rdata1", bus.m1_rdata, 32'h0);
        check1("rst mem_we", bus.mem_we, 1'b0);
        check32("rst mem_a", bus.mem_a, 32'h0);
        check32("rst mem_wd", bus.mem_wd, 32'h0);
        repeat (2) next_cycle();
        @(negedge clk);
        check1("rst held gnt0", bus.m0_gnt, 1'b0);
        check1("rst held rvalid0", bus.m0_rvalid, 1'b0);
        next_cycle();
        idle_all();
        rst = 1'b1;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            check1($sformatf("post-rst rvalid0 c%0d", t), bus.m0_rvalid, 1'b0);
            check1($sformatf("post-rst mem_a c%0d", t), bus.mem_a == 32'h0, 1'b1);
            next_cycle();
        end

        // ---------------- contention ----------------
        set_port(0, 1'b1, 1'b0, 32'h1, 32'h0);
        set_port(1, 1'b1, 1'b0, 32'h2, 32'h0);
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
`ifdef DMEM_ARB_FIXED_PRIO_EN
            check1($sformatf("contend c%0d gnt0", t), bus.m0_gnt, 1'b1);
            check1($sformatf("contend c%0d gnt1", t), bus.m1_gnt, 1'b0);
`else
            check1($sformatf("contend c%0d gnt0", t), bus.m0_gnt, (t % 2) == 0);
            check1($sformatf("contend c%0d gnt1", t), bus.m1_gnt, (t % 2) == 1);
`endif
            next_cycle();
        end
        set_port(0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check1("contend m0 dropped gnt1", bus.m1_gnt, 1'b1);
        next_cycle();
        idle_all();
        repeat (3) next_cycle();

        // ---------------- RAW across ports ----------------
        set_port(0, 1'b1, 1'b1, 32'h20, 32'h1234_5678);
        set_port(1, 1'b1, 1'b0, 32'h20, 32'h0);
        @(negedge clk);
        check1("raw N gnt0", bus.m0_gnt, 1'b1);
        check1("raw N gnt1", bus.m1_gnt, 1'b0);
        next_cycle();
        set_port(0, 1'b0, 1'b0, 32'h0, 32'h0);
        ref_mem[8'h20] = 32'h1234_5678;
        @(negedge clk);
        check1("raw N+1 gnt1", bus.m1_gnt, 1'b1);
        next_cycle();
        set_port(1, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check1("raw N+2 rvalid0", bus.m0_rvalid, 1'b0);
        check1("raw N+2 rvalid1", bus.m1_rvalid, 1'b0);
        next_cycle();
        @(negedge clk);
        check1("raw N+3 rvalid1", bus.m1_rvalid, 1'b1);
        check32("raw N+3 rdata1", bus.m1_rdata, 32'h1234_5678);
        next_cycle();
        repeat (2) next_cycle();

        // ---------------- back-to-back port-1 reads ----------------
        set_port(1, 1'b1, 1'b0, 32'h0, 32'h0);
        for (int t = 0; t < 7; t++) begin
            @(negedge clk);
            if (t < 4) check1($sformatf("b2b c%0d gnt1", t), bus.m1_gnt, 1'b1);
            if (t >= 2 && t < 6) begin
                check1($sformatf("b2b c%0d rvalid1", t), bus.m1_rvalid, 1'b1);
                check32($sformatf("b2b c%0d rdata1", t), bus.m1_rdata, ref_mem[t-2]);
            end
            if (t == 6) check1("b2b tail rvalid1", bus.m1_rvalid, 1'b0);
            check1($sformatf("b2b c%0d rvalid0", t), bus.m0_rvalid, 1'b0);
            next_cycle();
            if (t < 3) set_port(1, 1'b1, 1'b0, 32'(t + 1), 32'h0);
            else       set_port(1, 1'b0, 1'b0, 32'h0, 32'h0);
        end

        // ---------------- write silence ----------------
        we_cnt = 0;
        rv_cnt = 0;
        set_port(0, 1'b1, 1'b1, 32'h30, 32'hA5A5_5A5A);
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            if (bus.mem_we) we_cnt++;
            if (bus.m0_rvalid || bus.m1_rvalid) rv_cnt++;
            next_cycle();
            set_port(0, 1'b0, 1'b0, 32'h0, 32'h0);
        end
        ref_mem[8'h30] = 32'hA5A5_5A5A;
        check32("wsil mem_we cycles", 32'(we_cnt), 32'd1);
        check32("wsil rvalid cycles", 32'(rv_cnt), 32'd0);

        // ---------------- randomized traffic vs reference ----------------
        do_reset();
        pref       = 0;
        last_rd[0] = '0;
        last_rd[1] = '0;
        rsp_q.delete();
        wr_q.delete();
        cyc = 0;
        for (int k = 0; k < 2000; k++) begin
            int   winner;
            int   dens;
            logic granted [2];
            rsp_t r;
            wr_t  w;
            logic hit;

            @(negedge clk);
            // grant rule
            winner = -1;
            if (r_req[0] && r_req[1]) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
                winner = 0;
`else
                winner = pref;
                pref   = 1 - pref;
`endif
            end else if (r_req[0]) begin
                winner = 0;
            end else if (r_req[1]) begin
                winner = 1;
            end
            granted[0] = (winner == 0);
            granted[1] = (winner == 1);
            check1("rnd gnt0", bus.m0_gnt, granted[0]);
            check1("rnd gnt1", bus.m1_gnt, granted[1]);

            // read responses due this cycle
            hit = 1'b0;
            r   = '{0, 0, 32'h0};
            if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
                r   = rsp_q.pop_front();
                hit = 1'b1;
                last_rd[r.port] = r.data;
            end
            check1("rnd rvalid0", bus.m0_rvalid, hit && r.port == 0);
            check1("rnd rvalid1", bus.m1_rvalid, hit && r.port == 1);
            check32("rnd rdata0", bus.m0_rdata, last_rd[0]);
            check32("rnd rdata1", bus.m1_rdata, last_rd[1]);

            // memory writes due this cycle
            hit = 1'b0;
            w   = '{0, 32'h0, 32'h0};
            if (wr_q.size() > 0 && wr_q[0].due == cyc) begin
                w   = wr_q.pop_front();
                hit = 1'b1;
            end
            check1("rnd mem_we", bus.mem_we, hit);
            if (hit) begin
                check32("rnd mem_a", bus.mem_a, w.addr);
                check32("rnd mem_wd", bus.mem_wd, w.data);
            end

            // accesses take effect in grant order
            if (winner >= 0) begin
                if (r_we[winner]) begin
                    ref_mem[r_addr[winner][7:0]] = r_wdata[winner];
                    wr_q.push_back('{cyc + 1, r_addr[winner], r_wdata[winner]});
                end else begin
                    rsp_q.push_back('{cyc + 2, winner, ref_mem[r_addr[winner][7:0]]});
                end
            end

            next_cycle();
            cyc++;
            dens = (k / 250) % 4;
            for (int p = 0; p < 2; p++) begin
                if (!r_req[p] || granted[p]) begin
                    case (dens)
                        0:       r_req[p] = 1'b1;
                        1:       r_req[p] = ($urandom_range(0, 99) < 70);
                        2:       r_req[p] = ($urandom_range(0, 99) < 30);
                        default: r_req[p] = ($urandom_range(0, 99) < 90);
                    endcase
                    r_we[p]    = ($urandom_range(0, 2) == 0);
                    r_addr[p]  = 32'($urandom_range(0, 15));
                    r_wdata[p] = $urandom;
                end else if ($urandom_range(0, 7) == 0) begin
                    // pending requester revises its command while waiting
                    r_we[p]    = ~r_we[p];
                    r_addr[p]  = 32'($urandom_range(0, 15));
                    r_wdata[p] = $urandom;
                end
            end
            apply();
        end

        idle_all();
        repeat (4) next_cycle();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
